// File: rtl/uart_reg_responder_pkg.sv
// uart_reg_responder_pkg: protocol constants, command field positions and FSM state encoding
package uart_reg_responder_pkg;
  localparam logic [7:0] ACK_DEF = 8'h06;
  localparam logic [7:0] NAK_DEF = 8'h15;
  localparam int CMD_WR_BIT = 7;
  typedef enum logic [1:0] {IDLE, GET_DATA, RESP} state_t;
endpackage

// File: rtl/uart_reg_file.sv
// uart_reg_file: NUM_REGS x 8 register file (clk, reset, wr_en/wr_addr/wr_data write port, rd_addr/rd_data comb read, flat regs_out)
module uart_reg_file #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [7:0]              wr_data,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [7:0]              rd_data,
  output logic [NUM_REGS*8-1:0]   regs_out
);
  always_ff @(posedge clk)
    if (reset) regs_out <= '0;
    else if (wr_en) regs_out[{wr_addr, 3'b000} +: 8] <= wr_data;
  assign rd_data = regs_out[{rd_addr, 3'b000} +: 8];
endmodule

// File: rtl/uart_reg_responder.sv
// uart_reg_responder: UART byte command decoder (rx_valid/rx_ready/rx_bits in, tx_valid/tx_ready/tx_bits response, regs_out, wr_strobe/wr_addr, err_count)
module uart_reg_responder
  import uart_reg_responder_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W = 4,
  parameter int TIMEOUT = 100000,
  parameter logic [7:0] ACK = ACK_DEF,
  parameter logic [7:0] NAK = NAK_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [7:0]            rx_bits,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_bits,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            err_count
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [TW-1:0] timer;
  logic [7:0] rd_data;
  logic rx_fire, tx_fire, is_wr, illegal, timeout, we, err_inc;
  assign rx_ready = state != RESP;
  assign tx_valid = state == RESP;
  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;
  assign is_wr = rx_bits[CMD_WR_BIT];
  assign illegal = |rx_bits[6:ADDR_W];
  assign we = state == GET_DATA && rx_fire;
  assign timeout = state == GET_DATA && !rx_fire && timer == TW'(TIMEOUT - 1);
  assign err_inc = (state == IDLE && rx_fire && illegal) || timeout;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     state_n = rx_fire ? ((is_wr && !illegal) ? GET_DATA : RESP) : IDLE;
      GET_DATA: state_n = rx_fire ? RESP : (timeout ? IDLE : GET_DATA);
      RESP:     state_n = tx_fire ? IDLE : RESP;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      timer <= '0;
      tx_bits <= '0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      err_count <= '0;
    end else begin
      state <= state_n;
      wr_strobe <= we;
      if (we) wr_addr <= addr_q;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (state == IDLE && rx_fire) begin
        addr_q <= rx_bits[ADDR_W-1:0];
        timer <= '0;
        if (illegal || !is_wr) tx_bits <= illegal ? NAK : rd_data;
      end else if (state == GET_DATA) begin
        if (rx_fire) tx_bits <= ACK;
        else if (!timeout) timer <= timer + 1'b1;
      end
    end
  end
  uart_reg_file #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_file (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (we),
    .wr_addr  (addr_q),
    .wr_data  (rx_bits),
    .rd_addr  (rx_bits[ADDR_W-1:0]),
    .rd_data  (rd_data),
    .regs_out (regs_out)
  );
endmodule

// File: tb/tb_uart_reg_responder.sv
// tb_uart_reg_responder: directed self-checking bench for uart_reg_responder with TIMEOUT=50
module tb_uart_reg_responder;
  logic clk = 0, reset = 1, rx_valid = 0, tx_ready = 0;
  logic [7:0] rx_bits = 0;
  logic rx_ready, tx_valid, wr_strobe;
  logic [7:0] tx_bits, err_count;
  logic [127:0] regs_out;
  logic [3:0] wr_addr;
  int checks = 0, failures = 0;
  logic [127:0] exp_regs;
  always #5 clk = ~clk;
  uart_reg_responder #(.NUM_REGS(16), .ADDR_W(4), .TIMEOUT(50)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_bits(rx_bits),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_bits(tx_bits), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .err_count(err_count)
  );
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!rx_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("rx_ready_wait", rx_ready, 1);
    rx_valid = 1;
    rx_bits = b;
    @(posedge clk);
    #1 rx_valid = 0;
  endtask
  task automatic take(input string tag, input logic [7:0] exp);
    int n = 0;
    @(negedge clk);
    while (!tx_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, tx_valid, 1);
    chk(tag, tx_bits, exp);
    tx_ready = 1;
    @(posedge clk);
    #1 tx_ready = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    exp_regs = '0;
    do_reset();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_bits", tx_bits, 0);
    chk("rst_err", err_count, 0);
    chk("rst_regs", regs_out, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rx_ready", rx_ready, 1);
    send_byte(8'h83);
    chk("wcmd_tx_valid", tx_valid, 0);
    chk("wcmd_rx_ready", rx_ready, 1);
    send_byte(8'h5A);
    exp_regs[31:24] = 8'h5A;
    chk("wr_strobe", wr_strobe, 1);
    chk("wr_addr", wr_addr, 3);
    chk("wr_regs", regs_out, exp_regs);
    chk("wr_latency", tx_valid, 1);
    take("wr_ack", 8'h06);
    chk("wr_strobe_once", wr_strobe, 0);
    send_byte(8'h03);
    chk("rd_latency", tx_valid, 1);
    take("rd3", 8'h5A);
    send_byte(8'h40);
    take("ill_nak", 8'h15);
    chk("ill_err", err_count, 1);
    chk("ill_regs", regs_out, exp_regs);
    send_byte(8'h00);
    rx_valid = 1;
    rx_bits = 8'h03;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", tx_valid, 1);
      chk("bp_bits", tx_bits, 8'h00);
      chk("bp_rx_ready", rx_ready, 0);
    end
    tx_ready = 1;
    @(posedge clk);
    #1 tx_ready = 0;
    chk("bp_after_valid", tx_valid, 0);
    chk("bp_after_rx_ready", rx_ready, 1);
    @(posedge clk);
    #1 rx_valid = 0;
    chk("bp_queued_valid", tx_valid, 1);
    chk("bp_queued_bits", tx_bits, 8'h5A);
    take("bp_queued", 8'h5A);
    send_byte(8'h81);
    for (int i = 1; i < 50; i++) begin
      @(posedge clk);
      #1;
      chk("to_wait_err", err_count, 1);
      chk("to_wait_tx", tx_valid, 0);
    end
    @(posedge clk);
    #1;
    chk("to_err", err_count, 2);
    chk("to_tx", tx_valid, 0);
    chk("to_regs", regs_out, exp_regs);
    send_byte(8'h01);
    take("to_rd1", 8'h00);
    send_byte(8'h82);
    repeat (49) @(posedge clk);
    send_byte(8'h77);
    exp_regs[23:16] = 8'h77;
    take("edge_ack", 8'h06);
    chk("edge_err", err_count, 2);
    chk("edge_regs", regs_out, exp_regs);
    send_byte(8'h8F);
    do_reset();
    chk("mid_rst_regs", regs_out, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_tx_bits", tx_bits, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_strobe", wr_strobe, 0);
    send_byte(8'h05);
    take("fresh_rd5", 8'h00);
    chk("fresh_regs", regs_out, 0);
    for (int i = 0; i < 300; i++) begin
      send_byte(8'h40);
      take("sat_nak", 8'h15);
    end
    chk("sat_err", err_count, 8'hFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
